// File: rtl/lzc_pkg.sv
// lzc_pkg: shared FSM state and mode encodings for the iterative leading-count unit
package lzc_pkg;
  typedef enum logic [1:0] {
    LZC_IDLE = 2'd0,
    LZC_SCAN = 2'd1,
    LZC_DONE = 2'd2
  } lzc_state_e;
  localparam logic LZC_MODE_CLZ = 1'b0;
  localparam logic LZC_MODE_CLO = 1'b1;
endpackage

// File: rtl/lzc_chunk_enc.sv
// lzc_chunk_enc: combinational leading-zero priority encoder for one CHUNK-bit slice
module lzc_chunk_enc #(
  parameter int CHUNK = 8,
  parameter int LZ_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic [LZ_W-1:0]  lz_o,
  output logic             zero_o
);
  always_comb begin
    lz_o = LZ_W'(CHUNK);
    // ascending scan so the most significant set bit assigns last and wins
    for (int i = 0; i < CHUNK; i++)
      if (chunk_i[i]) lz_o = LZ_W'(CHUNK - 1 - i);
  end
  assign zero_o = ~|chunk_i;
endmodule

// File: rtl/lzc_iter_unit.sv
// lzc_iter_unit: multi-cycle CLZ/CLO counter scanning CHUNK bits per cycle from the MSB
module lzc_iter_unit
  import lzc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RES_W-1:0] result_o
);
  localparam int N    = WIDTH / CHUNK;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int LZ_W = $clog2(CHUNK + 1);
  lzc_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [LZ_W-1:0]  lz;
  logic             zero;
  lzc_chunk_enc #(.CHUNK(CHUNK), .LZ_W(LZ_W)) u_enc (
    .chunk_i (sh_q[WIDTH-1 -: CHUNK]),
    .lz_o    (lz),
    .zero_o  (zero)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LZC_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    res_d   = res_q;
    if (state_q == LZC_SCAN) begin
      if (!zero) begin
        res_d   = RES_W'(cnt_q + CW'(lz));
        state_d = LZC_DONE;
      end else if (idx_q == IW'(N - 1)) begin
        res_d   = RES_W'(WIDTH);
        state_d = LZC_DONE;
      end else begin
        cnt_d = cnt_q + CW'(CHUNK);
        sh_d  = sh_q << CHUNK;
        idx_d = idx_q + 1'b1;
      end
    end else if (start_i) begin
      // CLO is CLZ of the complemented operand, so only one encoder is needed
      sh_d    = (mode_i == LZC_MODE_CLO) ? ~operand_i : operand_i;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = LZC_SCAN;
    end else begin
      state_d = LZC_IDLE;
    end
  end
  assign busy_o   = (state_q == LZC_SCAN);
  assign done_o   = (state_q == LZC_DONE);
  assign result_o = res_q;
endmodule

// File: tb/tb_lzc_iter_unit.sv
// tb_lzc_iter_unit: vector table, hand-written corner sequences and random sweep with a result/latency scoreboard
module tb_lzc_iter_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] operand_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  int checks = 0;
  int failures = 0;
  int exp_res_q[$];
  int exp_cyc_q[$];
  typedef struct {
    logic [31:0] op;
    logic        mode;
    int          res;
    int          cyc;
  } vec_t;
  vec_t vecs[10];
  lzc_iter_unit #(.WIDTH(32), .CHUNK(8), .RES_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .operand_i (operand_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );
  always #5 clk = ~clk;
  function automatic int model_cnt(logic [31:0] op, logic mode);
    logic [31:0] v;
    int n;
    v = mode ? ~op : op;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction
  function automatic int model_cyc(int n);
    return (n == 32) ? 4 : n / 8 + 1;
  endfunction
  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic issue(logic [31:0] op, logic mode, int res, int cyc);
    start_i   = 1'b1;
    operand_i = op;
    mode_i    = mode;
    exp_res_q.push_back(res);
    exp_cyc_q.push_back(cyc);
  endtask
  // counts busy cycles from the current negedge until done is seen, then scores it
  task automatic collect(string name);
    int n = 0;
    int g = 0;
    int er, ec;
    while (!done_o && g < 40) begin
      n += busy_o ? 1 : 0;
      g++;
      @(negedge clk);
    end
    if (exp_res_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    er = exp_res_q.pop_front();
    ec = exp_cyc_q.pop_front();
    if (!done_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", name, g);
      return;
    end
    check({name, "_result"}, result_o, er);
    check({name, "_cycles"}, n, ec);
  endtask
  task automatic run_op(string name, logic [31:0] op, logic mode, int res, int cyc);
    @(negedge clk);
    issue(op, mode, res, cyc);
    @(negedge clk);
    start_i = 1'b0;
    collect(name);
    @(negedge clk);
    check({name, "_done_pulse"}, done_o, 0);
    check({name, "_held"}, result_o, res);
  endtask
  initial begin
    vecs[0] = '{32'h8000_0000, 1'b0, 0, 1};
    vecs[1] = '{32'h0000_0001, 1'b0, 31, 4};
    vecs[2] = '{32'h0000_0000, 1'b0, 32, 4};
    vecs[3] = '{32'hFFF0_0000, 1'b1, 12, 2};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 32, 4};
    vecs[5] = '{32'h00FF_0000, 1'b0, 8, 2};
    vecs[6] = '{32'h0000_0100, 1'b0, 23, 3};
    vecs[7] = '{32'h7FFF_FFFF, 1'b1, 0, 1};
    vecs[8] = '{32'hFFFF_FFFE, 1'b1, 31, 4};
    vecs[9] = '{32'hFFFF_FFFF, 1'b0, 0, 1};
    repeat (3) @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_result", result_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].mode, vecs[i].res, vecs[i].cyc);
    // start while busy is ignored, then a start in the DONE cycle is accepted
    @(negedge clk);
    issue(32'h0001_0000, 1'b0, 15, 2);
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = 32'hFFFF_FFFF;
    mode_i    = 1'b1;
    fork
      collect("busy_ignore");
      begin
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    issue(32'h0000_8000, 1'b0, 16, 3);
    @(negedge clk);
    start_i = 1'b0;
    collect("done_restart");
    @(negedge clk);
    check("done_restart_pulse", done_o, 0);
    // async reset in the second SCAN cycle of a full-length scan
    @(negedge clk);
    issue(32'h0000_0000, 1'b0, 32, 4);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    void'(exp_res_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (6) begin
        @(negedge clk);
        seen += (done_o || busy_o) ? 1 : 0;
      end
      check("rst_no_done", seen, 0);
    end
    run_op("after_rst", 32'h0040_0000, 1'b0, 9, 2);
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] op;
      logic        m;
      int          n;
      op = $urandom >> $urandom_range(0, 32);
      m  = 1'($urandom_range(0, 1));
      if (m) op = ~op;
      n  = model_cnt(op, m);
      run_op("rand", op, m, n, model_cyc(n));
    end
    check("scoreboard_empty", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
